// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential signed radix-2 Booth multiplier:
//   MULT_WIDTH   default operand width
//   state_e      controller states (IDLE / RUN / DONE)
//   booth_op_e   per-step Booth operation (NOP / ADD / SUB)
//   cnt_width()  width of the step counter for a given operand width
//   booth_decode() maps {Q[0], q_1} onto a Booth operation
// ---------------------------------------------------------------------------
package mult_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_e;

    // One extra bit so the counter can represent WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    // Radix-2 Booth recoding of the current multiplier bit pair.
    function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
        booth_op_e op;
        case ({q0, q_1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_multiplier_step.sv
// ---------------------------------------------------------------------------
// booth_step
// One combinational radix-2 Booth iteration: add/subtract the sign-extended
// multiplicand into the accumulator according to {Q[0], q_1}, then shift the
// concatenation {A, Q, q_1} right arithmetically by one bit.
//
// Ports:
//   a_i    [WIDTH:0]    current accumulator (sign-extended)
//   q_i    [WIDTH-1:0]  current multiplier / low product bits
//   q1_i                current extra bit to the right of Q
//   mx_i   [WIDTH:0]    sign-extended multiplicand
//   a_o, q_o, q1_o      next {A, Q, q_1}
// ---------------------------------------------------------------------------
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    input  logic [WIDTH:0]   mx_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    booth_op_e        op;
    logic [WIDTH:0]   sum;

    assign op = booth_decode(q_i[0], q1_i);

    // (WIDTH+1)-bit modulo arithmetic; the extra bit keeps A - M exact even
    // when M is the most negative WIDTH-bit value.
    always_comb begin
        sum = a_i;
        case (op)
            OP_ADD:  sum = a_i + mx_i;
            OP_SUB:  sum = a_i - mx_i;
            default: sum = a_i;
        endcase
    end

    // Arithmetic right shift of {sum, Q, q_1}: sum's MSB replicates.
    assign a_o  = {sum[WIDTH], sum[WIDTH:1]};
    assign q_o  = {sum[0], q_i[WIDTH-1:1]};
    assign q1_o = q_i[0];

endmodule

// File: rtl/booth_multiplier.sv
// ---------------------------------------------------------------------------
// booth_multiplier
// Sequential signed radix-2 Booth multiplier. A start request in IDLE
// captures both operands; WIDTH Booth steps follow (one per cycle), then a
// DONE cycle registers the 2*WIDTH-bit product into HI/LO and pulses multOut.
// Latency from the start edge to the multOut edge is WIDTH+1 cycles.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset, aborts any operation
//   MultCtrl       start request, honoured only in IDLE
//   multiplicando  signed multiplicand M
//   multiplicador  signed multiplier Q
//   busy           high while in RUN or DONE (registered)
//   multOut        one-cycle completion pulse
//   HI / LO        upper / lower halves of the product, held until next result
// ---------------------------------------------------------------------------
module booth_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultCtrl,
    input  logic [WIDTH-1:0] multiplicando,
    input  logic [WIDTH-1:0] multiplicador,
    output logic             busy,
    output logic             multOut,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH:0]   mx_q, mx_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;
    logic             q1_step;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_i  (a_q),
        .q_i  (q_q),
        .q1_i (q1_q),
        .mx_i (mx_q),
        .a_o  (a_step),
        .q_o  (q_step),
        .q1_o (q1_step)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            mx_q    <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            mx_q    <= mx_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        mx_d    = mx_q;
        q_d     = q_q;
        q1_d    = q1_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (MultCtrl) begin
                    a_d     = '0;
                    q_d     = multiplicador;
                    q1_d    = 1'b0;
                    mx_d    = {multiplicando[WIDTH-1], multiplicando};
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_step;
                q_d     = q_step;
                q1_d    = q1_step;
                count_d = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A's extra top bit is only a sign copy at this point.
                hi_d    = a_q[WIDTH-1:0];
                lo_d    = q_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered busy tracks the state being entered.
        busy_d = (state_d != ST_IDLE);
    end

    assign busy    = busy_q;
    assign multOut = done_q;
    assign HI      = hi_q;
    assign LO      = lo_q;

endmodule

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
- Sequential signed radix-2 Booth multiplier for the processor datapath; the multiply counterpart of the iterative divider.
- Takes two WIDTH-bit two's-complement operands on a one-cycle start request.
- Produces the 2·WIDTH-bit product into HI (upper half) and LO (lower half) after a fixed WIDTH+1-cycle latency, with a one-cycle completion pulse for the control unit.

Parameters:
- WIDTH, 32, operand width; the product is 2·WIDTH bits, split across HI and LO.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- MultCtrl  input  1  start request; sampled only in IDLE
- multiplicando  input  WIDTH  signed multiplicand M
- multiplicador  input  WIDTH  signed multiplier Q
- busy  output  1  high while in RUN or DONE
- multOut  output  1  one-cycle pulse; HI/LO valid from this cycle on
- HI  output  WIDTH  product bits [2·WIDTH-1:WIDTH]
- LO  output  WIDTH  product bits [WIDTH-1:0]

Behaviour:
- Reset (synchronous, highest priority, any state including mid-operation):
  - state=IDLE; HI=0, LO=0, multOut=0, busy=0.
  - Internal A, Q, q_1 and count cleared.
  - Any in-flight operation is discarded with no completion pulse.
- Internal registers:
  - A: WIDTH+1 bits, sign-extended accumulator; the extra bit absorbs the overflow of A−M when M is the most negative value.
  - Q: WIDTH bits.
  - q_1: 1 bit.
  - Mx: WIDTH+1 bits, sign-extended M.
  - count: clog2(WIDTH)+1 bits.
- IDLE:
  - On MultCtrl=1 at edge N: A=0, Q=multiplicador, q_1=0, Mx=sign-extended multiplicando, count=0, state→RUN.
  - Operands are captured only at this edge; later operand changes have no effect.
- RUN, one Booth step per cycle:
  - Decode {Q[0],q_1}: 00/11 no operation; 01 A=A+Mx; 10 A=A−Mx. All arithmetic is (WIDTH+1)-bit modulo.
  - Then arithmetic right shift of {A,Q,q_1} by one; A's MSB replicates.
  - count increments. The step at count==WIDTH−1 is the last; state→DONE. RUN occupies edges N+1..N+WIDTH.
- DONE (edge N+WIDTH+1):
  - HI=A[WIDTH-1:0], LO=Q, multOut=1 for exactly this cycle, state→IDLE.
  - At the next edge multOut=0.
- HI/LO hold their value until the next completion or reset.
- MultCtrl while busy: ignored, not queued.
- MultCtrl held high continuously: a new operation starts in the IDLE cycle immediately after DONE. Back-to-back throughput is one result every WIDTH+2 cycles.
- Arithmetic and boundary rules:
  - The product is the exact signed 2·WIDTH-bit result for all operand pairs, including −2^(WIDTH−1)·−2^(WIDTH−1).
  - No overflow flag exists, since no overflow is possible.
  - A zero operand takes the same full latency; there is no early termination.
- busy is registered: it rises at edge N and falls at edge N+WIDTH+1.

Decomposition:
- Shared package (mult_pkg):
  - MULT_WIDTH default (32).
  - State encoding constants IDLE/RUN/DONE (2 bits).
  - Booth op encoding NOP/ADD/SUB.
  - Count width function.
- One natural sub-module, booth_step:
  - Purely combinational.
  - Inputs {A,Q,q_1} and Mx; output the next {A,Q,q_1} after add/sub and the arithmetic shift.
  - The top level holds the FSM, counter and output registers.

Test Plan:
- Basic positive: start with multiplicando=3, multiplicador=5 → multOut pulses exactly 33 cycles after the start edge; HI=0x00000000, LO=0x0000000F; busy high for 33 cycles.
- Negative: −3 (0xFFFFFFFD) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; −7 × −6 → HI=0, LO=0x0000002A.
- Extremes:
  - 0x80000000 × 0x80000000 → HI=0x40000000, LO=0x00000000.
  - 0x80000000 × 0xFFFFFFFF → HI=0x00000000, LO=0x80000000.
  - 0x7FFFFFFF × 0x7FFFFFFF → HI=0x3FFFFFFF, LO=0x00000001.
- Busy/operand isolation: start 2×3, then at cycle 5 pulse MultCtrl with operands 9×9 and change the inputs → first result HI=0, LO=6; second request ignored; no second multOut.
- Reset mid-operation: start 1234×5678, assert reset at cycle 10 for one cycle → HI=LO=0, busy=0, no multOut. A fresh start 4×4 then yields LO=16 after 33 cycles.
- Back-to-back: MultCtrl held high with operands 2×−1 → multOut pulses every 34 cycles; each result is HI=0xFFFFFFFF, LO=0xFFFFFFFE.
